pls_adapter: RTL
================

PLS_ADAPTER -- requirements
Module: pls_adapter

Interface
REQ-001 Parameter PLS_INIT, default 8'd50, Pls value loaded at reset.
REQ-002 Parameter PLS_STEP, default 8'd4, adjustment step per window.
REQ-003 Parameter PLS_MIN, default 8'd8, lower saturation bound.
REQ-004 Parameter PLS_MAX, default 8'd248, upper saturation bound.
REQ-005 Parameter WINDOW_LOG2, default 4, window length = 2^WINDOW_LOG2 moves (16).
REQ-006 in_clock  input  1  system clock; all state on rising edge.
REQ-007 in_reset_n  input  1  asynchronous, active-low reset.
REQ-008 in_enable  input  1  adaptation enable; 0 freezes counters and Pls.
REQ-009 in_move_valid  input  1  one completed MCMC move reported this cycle.
REQ-010 in_move_is_local  input  1  the reported move was local (1) or global (0).
REQ-011 in_move_accepted  input  1  the reported move was accepted.
REQ-012 out_ready  output  1  block accepts move reports this cycle.
REQ-013 out_Pls  output  8  current local-move probability, drives ProbabilityAdjustment in_Pls.
REQ-014 out_pls_updated  output  1  one-cycle pulse when a window evaluation completes.

Function
REQ-015 States: IDLE, COLLECT, COMPARE, UPDATE; one-hot or binary at implementer's choice.
REQ-016 IDLE -> COLLECT when in_enable=1; COLLECT -> IDLE when in_enable=0, counters cleared, out_Pls held.
REQ-017 A move is counted only when in_move_valid=1, out_ready=1 and in_enable=1; otherwise ignored.
REQ-018 COLLECT keeps four counters, width WINDOW_LOG2+1: local_att, local_acc, global_att, global_acc; accepted implies attempted.
REQ-019 out_ready=1 only in COLLECT; 0 in IDLE, COMPARE, UPDATE.
REQ-020 When the 2^WINDOW_LOG2-th move of a window is counted, next state COMPARE (same edge counts that move).
REQ-021 COMPARE: register products A=local_acc*global_att and B=global_acc*local_att, width 2*(WINDOW_LOG2+1), unsigned, no division.
REQ-022 UPDATE decision: local_att=0 or global_att=0 -> no change; A>B -> out_Pls=min(out_Pls+PLS_STEP, PLS_MAX); A<B -> out_Pls=max(out_Pls-PLS_STEP, PLS_MIN); A=B -> no change.
REQ-023 Saturation computed in 9-bit arithmetic; out_Pls never wraps and never leaves [PLS_MIN, PLS_MAX].
REQ-024 UPDATE: out_Pls written, out_pls_updated=1 for exactly that cycle (also when value unchanged), counters cleared, next state COLLECT (or IDLE if in_enable=0).
REQ-025 Latency: last move of window at edge N -> out_Pls new value and out_pls_updated visible after edge N+2.
REQ-026 in_enable falling during COMPARE or UPDATE: evaluation completes and Pls updates, then IDLE.
REQ-027 in_move_valid asserted while out_ready=0: dropped, no counter change, no error flag.

Reset
REQ-028 in_reset_n=0 asynchronously forces state IDLE, all counters 0, out_Pls=PLS_INIT, out_ready=0, out_pls_updated=0.
REQ-029 Reset asserted mid-window or mid-UPDATE discards partial counts; no out_pls_updated pulse generated.
REQ-030 Reset release synchronous to in_clock; first counted move no earlier than first edge after release with in_enable=1.

Verification
REQ-031 Reset, enable, 16 moves: 8 local all accepted, 8 global none accepted -> out_Pls 50->54, one out_pls_updated pulse two cycles after 16th move.
REQ-032 Window of 8 local 0 accepted, 8 global 8 accepted -> out_Pls 50->46; repeat 12 windows -> out_Pls saturates at 8, stays 8.
REQ-033 Window of 16 local moves, 0 global -> out_Pls unchanged 50, out_pls_updated still pulses.
REQ-034 Window 4/8 local accepted, 4/8 global accepted (A=B=32) -> out_Pls unchanged; in_move_valid held high during COMPARE/UPDATE -> those reports not counted (next window needs full 16 more).
REQ-035 Drive out_Pls to 248 via repeated local-favoured windows -> stays 248, never 252 or wrapped.
REQ-036 Assert in_reset_n=0 after 10 moves of a window -> out_Pls=50 immediately, no pulse; after release next pulse only after 16 fresh moves.

Source files
------------

// File: rtl/pls_adapter.sv
// pls_adapter: adapts the local-move probability Pls from windowed acceptance statistics
module pls_adapter #(
  parameter logic [7:0] PLS_INIT    = 8'd50,
  parameter logic [7:0] PLS_STEP    = 8'd4,
  parameter logic [7:0] PLS_MIN     = 8'd8,
  parameter logic [7:0] PLS_MAX     = 8'd248,
  parameter int         WINDOW_LOG2 = 4
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_enable,
  input  logic       in_move_valid,
  input  logic       in_move_is_local,
  input  logic       in_move_accepted,
  output logic       out_ready,
  output logic [7:0] out_Pls,
  output logic       out_pls_updated
);
  localparam int CW = WINDOW_LOG2 + 1;
  localparam int PW = 2 * CW;
  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, UPDATE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] la_q, la_d, lc_q, lc_d, ga_q, ga_d, gc_q, gc_d;
  logic [PW-1:0] a_q, a_d, b_q, b_d;
  logic [7:0] pls_q, pls_d, pls_inc, pls_dec, pls_new;
  logic upd_q, upd_d, take, last;
  logic [CW-1:0] total;
  logic [8:0] up, dn;
  assign out_ready       = state_q == COLLECT;
  assign out_Pls         = pls_q;
  assign out_pls_updated = upd_q;
  assign take  = out_ready & in_enable & in_move_valid;
  assign total = la_q + ga_q;
  assign last  = take && total == CW'((1 << WINDOW_LOG2) - 1);
  // 9-bit arithmetic so neither direction can wrap before clamping
  assign up      = {1'b0, pls_q} + {1'b0, PLS_STEP};
  assign dn      = {1'b0, pls_q} - {1'b0, PLS_STEP};
  assign pls_inc = up > {1'b0, PLS_MAX} ? PLS_MAX : up[7:0];
  assign pls_dec = (dn[8] || dn < {1'b0, PLS_MIN}) ? PLS_MIN : dn[7:0];
  assign pls_new = (la_q == '0 || ga_q == '0 || a_q == b_q) ? pls_q :
                   a_q > b_q ? pls_inc : pls_dec;
  // next-state logic: count moves, form cross products, apply the step decision
  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    lc_d    = lc_q;
    ga_d    = ga_q;
    gc_d    = gc_q;
    a_d     = a_q;
    b_d     = b_q;
    pls_d   = pls_q;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: state_d = in_enable ? COLLECT : IDLE;
      COLLECT: begin
        if (!in_enable) begin
          state_d = IDLE;
          la_d    = '0;
          lc_d    = '0;
          ga_d    = '0;
          gc_d    = '0;
        end else if (take) begin
          la_d    = la_q + CW'(in_move_is_local);
          lc_d    = lc_q + CW'(in_move_is_local & in_move_accepted);
          ga_d    = ga_q + CW'(!in_move_is_local);
          gc_d    = gc_q + CW'(!in_move_is_local & in_move_accepted);
          state_d = last ? COMPARE : COLLECT;
        end
      end
      COMPARE: begin
        a_d     = PW'(lc_q) * PW'(ga_q);
        b_d     = PW'(gc_q) * PW'(la_q);
        state_d = UPDATE;
      end
      UPDATE: begin
        pls_d   = pls_new;
        upd_d   = 1'b1;
        la_d    = '0;
        lc_d    = '0;
        ga_d    = '0;
        gc_d    = '0;
        state_d = in_enable ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters, products and Pls register with asynchronous reset
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      la_q    <= '0;
      lc_q    <= '0;
      ga_q    <= '0;
      gc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pls_q   <= PLS_INIT;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lc_q    <= lc_d;
      ga_q    <= ga_d;
      gc_q    <= gc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pls_q   <= pls_d;
      upd_q   <= upd_d;
    end
  end
endmodule
